// File: rtl/intr_gen_pkg.sv
// Shared types and defaults for the intr_gen interrupt source block.
// Holds the delivery FSM encoding and a width helper for the internal counters.
package intr_gen_pkg;

    localparam int DEFAULT_PRESCALE = 50;
    localparam int DEFAULT_HOLDOFF  = 4;

    localparam int SRC_TIMER = 0;
    localparam int SRC_EXT   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Bits needed to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/intr_gen_sync_edge.sv
// Two-flop synchroniser plus delay flop and rising-edge detector for one
// asynchronous input line; reusable for any future external event input.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // s3 lags s2 by one cycle, so a held level yields exactly one request.
    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/intr_gen.sv
// Interrupt source: periodic timer drives intr1, synchronised external edge
// drives intr2; requests are latched and delivered as spaced one-cycle pulses.
module intr_gen
    import intr_gen_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE,
    parameter int HOLDOFF  = DEFAULT_HOLDOFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ext_evt,
    input  logic       en,
    input  logic [7:0] period,
    output logic       intr1,
    output logic       intr2,
    output logic [1:0] pending,
    output logic [1:0] ovf,
    output logic [7:0] count
);

    localparam int PW = cnt_width(PRESCALE);
    localparam int HW = cnt_width(HOLDOFF);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          tick;

    logic [7:0]    count_q;
    logic [7:0]    count_d;
    logic [8:0]    count_inc;
    logic          timer_req;

    logic          ext_rise;

    logic [1:0]    req;
    logic [1:0]    serve;
    logic [1:0]    pending_q;
    logic [1:0]    pending_d;
    logic [1:0]    ovf_q;
    logic [1:0]    ovf_d;

    state_e        state_q;
    logic [HW-1:0] hold_q;
    logic          intr1_q;
    logic          intr2_q;

    assign tick = (pre_q == PW'(PRESCALE - 1));

    always_comb begin
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    // Compare in 9 bits so period=255 with count=254 still wraps cleanly.
    assign count_inc = {1'b0, count_q} + 9'd1;

    always_comb begin
        count_d   = count_q;
        timer_req = 1'b0;
        if (!en || period == 8'd0) begin
            count_d = '0;
        end else if (tick) begin
            if (count_inc >= {1'b0, period}) begin
                count_d   = '0;
                timer_req = 1'b1;
            end else begin
                count_d = count_inc[7:0];
            end
        end
    end

    sync_edge u_ext_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ext_evt),
        .rise  (ext_rise)
    );

    assign req[SRC_TIMER] = timer_req;
    assign req[SRC_EXT]   = ext_rise;

    // A fresh request in the serve cycle re-arms the bit without counting as overrun.
    always_comb begin
        serve = 2'b00;
        if (state_q == IDLE) begin
            if (pending_q[SRC_TIMER]) begin
                serve[SRC_TIMER] = 1'b1;
            end else if (pending_q[SRC_EXT]) begin
                serve[SRC_EXT] = 1'b1;
            end
        end
        pending_d = req | (pending_q & ~serve);
        ovf_d     = ovf_q | (req & pending_q & ~serve);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q     <= '0;
            count_q   <= '0;
            pending_q <= '0;
            ovf_q     <= '0;
        end else begin
            pre_q     <= pre_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    // Hold exits on the edge where the counter would reach zero, giving
    // HOLDOFF+1 cycles between pulse rising edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            intr1_q <= 1'b0;
            intr2_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (serve != 2'b00) begin
                        state_q <= FIRE;
                        intr1_q <= serve[SRC_TIMER];
                        intr2_q <= serve[SRC_EXT];
                    end
                end
                FIRE: begin
                    state_q <= HOLD;
                    intr1_q <= 1'b0;
                    intr2_q <= 1'b0;
                    hold_q  <= HW'(HOLDOFF - 1);
                end
                HOLD: begin
                    if (hold_q <= HW'(1)) begin
                        state_q <= IDLE;
                    end else begin
                        hold_q <= hold_q - HW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    intr1_q <= 1'b0;
                    intr2_q <= 1'b0;
                end
            endcase
        end
    end

    assign intr1   = intr1_q;
    assign intr2   = intr2_q;
    assign pending = pending_q;
    assign ovf     = ovf_q;
    assign count   = count_q;

endmodule

// File: tb/tb_intr_gen.sv
// Scoreboard bench for intr_gen (PRESCALE=1, HOLDOFF=4): stimulus pushes
// expected pulses with their cycle numbers, a negedge monitor pops and compares.
module tb_intr_gen;

    typedef struct {
        bit isTimer;
        int cyc;
    } pulse_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       extEvt = 1'b0;
    logic       en = 1'b0;
    logic [7:0] period = 8'd0;
    logic       intr1;
    logic       intr2;
    logic [1:0] pending;
    logic [1:0] ovf;
    logic [7:0] count;

    pulse_t expQ[$];
    pulse_t monPulse;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     c;

    intr_gen #(
        .PRESCALE (1),
        .HOLDOFF  (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ext_evt (extEvt),
        .en      (en),
        .period  (period),
        .intr1   (intr1),
        .intr2   (intr2),
        .pending (pending),
        .ovf     (ovf),
        .count   (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic enV, input logic [7:0] periodV, input logic extV);
        en     = enV;
        period = periodV;
        extEvt = extV;
    endtask

    task automatic expectPulse(input bit isTimer, input int at);
        pulse_t p;
        p.isTimer = isTimer;
        p.cyc     = at;
        expQ.push_back(p);
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Caller is at a negedge; reset is asserted there and outputs must clear at once.
    task automatic resetDut();
        reset = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0);
        #1;
        checkOutput("resetIntr1", intr1, 0);
        checkOutput("resetIntr2", intr2, 0);
        checkOutput("resetPending", pending, 0);
        checkOutput("resetOvf", ovf, 0);
        checkOutput("resetCount", count, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: flags overdue expectations, then matches any presented pulse.
    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL missedPulse: got none, expected %s pulse at cycle %0d",
                     expQ[0].isTimer ? "intr1" : "intr2", expQ[0].cyc);
            void'(expQ.pop_front());
        end
        if (intr1 === 1'b1 || intr2 === 1'b1) begin
            checkOutput("pulseExclusive", {31'd0, intr1 & intr2}, 0);
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedPulse: got intr1=%0b intr2=%0b, expected none (cycle %0d)",
                         intr1, intr2, cyc);
            end else begin
                monPulse = expQ.pop_front();
                checkOutput("pulseKind", {31'd0, intr1}, {31'd0, monPulse.isTimer});
                checkOutput("pulseCycle", cyc, monPulse.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        resetDut();

        // Periodic timer, period 6: count 1..5,0 and intr1 every 6 cycles.
        @(negedge clk);
        c = cyc;
        applyStimulus(1'b1, 8'd6, 1'b0);
        expectPulse(1'b1, c + 7);
        expectPulse(1'b1, c + 13);
        expectPulse(1'b1, c + 19);
        for (int i = 1; i <= 6; i++) begin
            waitUntil(c + i);
            checkOutput("timerCount", count, i % 6);
        end
        waitUntil(c + 20);
        applyStimulus(1'b0, 8'd6, 1'b0);
        waitUntil(c + 28);
        checkOutput("timerOvf", ovf, 0);
        checkOutput("disabledCount", count, 0);
        checkOutput("timerPending", pending, 0);

        // External edge held high: one intr2, four edges after sampling.
        @(negedge clk);
        resetDut();
        @(negedge clk);
        c = cyc;
        applyStimulus(1'b0, 8'd0, 1'b1);
        expectPulse(1'b0, c + 4);
        waitUntil(c + 3);
        checkOutput("extPendingSet", pending, 2);
        waitUntil(c + 4);
        checkOutput("extPendingClr", pending, 0);
        waitUntil(c + 20);
        applyStimulus(1'b0, 8'd0, 1'b0);
        waitUntil(c + 30);
        checkOutput("extOvf", ovf, 0);

        // Simultaneous timer and ext requests: intr1 first, intr2 five cycles later.
        @(negedge clk);
        resetDut();
        @(negedge clk);
        c = cyc;
        applyStimulus(1'b1, 8'd4, 1'b0);
        expectPulse(1'b1, c + 5);
        expectPulse(1'b0, c + 10);
        waitUntil(c + 1);
        applyStimulus(1'b1, 8'd4, 1'b1);
        waitUntil(c + 4);
        checkOutput("bothPending", pending, 3);
        applyStimulus(1'b0, 8'd4, 1'b1);
        waitUntil(c + 20);
        applyStimulus(1'b0, 8'd0, 1'b0);
        waitUntil(c + 26);
        checkOutput("simulPending", pending, 0);
        checkOutput("simulOvf", ovf, 0);

        // Overrun: a request every cycle, pulses spaced five apart, ovf[0] sticky.
        @(negedge clk);
        resetDut();
        @(negedge clk);
        c = cyc;
        applyStimulus(1'b1, 8'd1, 1'b0);
        expectPulse(1'b1, c + 2);
        expectPulse(1'b1, c + 7);
        expectPulse(1'b1, c + 12);
        expectPulse(1'b1, c + 17);
        expectPulse(1'b1, c + 22);
        waitUntil(c + 2);
        checkOutput("ovfSetWins", ovf, 0);
        waitUntil(c + 3);
        checkOutput("ovfRaised", ovf, 1);
        waitUntil(c + 18);
        applyStimulus(1'b0, 8'd1, 1'b0);
        waitUntil(c + 30);
        checkOutput("ovfSticky", ovf, 1);
        checkOutput("ovfPendingDrained", pending, 0);

        // Period lowered below count wraps on the next tick; period 0 disables.
        @(negedge clk);
        resetDut();
        @(negedge clk);
        c = cyc;
        applyStimulus(1'b1, 8'd200, 1'b0);
        waitUntil(c + 50);
        checkOutput("countBeforeChange", count, 50);
        applyStimulus(1'b1, 8'd5, 1'b0);
        expectPulse(1'b1, c + 52);
        waitUntil(c + 51);
        checkOutput("countWrapped", count, 0);
        checkOutput("wrapPending", pending, 1);
        applyStimulus(1'b1, 8'd0, 1'b0);
        waitUntil(c + 72);
        checkOutput("periodZeroCount", count, 0);
        checkOutput("periodZeroPending", pending, 0);

        // Reset one cycle into hold with the ext request still pending.
        @(negedge clk);
        resetDut();
        @(negedge clk);
        c = cyc;
        applyStimulus(1'b1, 8'd4, 1'b0);
        expectPulse(1'b1, c + 5);
        waitUntil(c + 1);
        applyStimulus(1'b1, 8'd4, 1'b1);
        waitUntil(c + 4);
        applyStimulus(1'b0, 8'd4, 1'b1);
        waitUntil(c + 6);
        checkOutput("holdPending", pending, 2);
        resetDut();
        waitUntil(c + 30);
        checkOutput("afterResetPending", pending, 0);
        @(negedge clk);
        c = cyc;
        applyStimulus(1'b0, 8'd0, 1'b1);
        expectPulse(1'b0, c + 4);
        waitUntil(c + 10);
        applyStimulus(1'b0, 8'd0, 1'b0);
        waitUntil(c + 15);
        checkOutput("newEdgePending", pending, 0);

        checkOutput("queueEmpty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
